// File: rtl/gift_ise_inv_seq.sv
// gift_ise_inv_seq: multi-cycle inverse GIFT key update / permbits step, valid-ready unit.
// Optional GIFT_ISE_INV_UNROLL4_EN: up to four inverse key updates per busy cycle.
module gift_ise_inv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] rs1,
  input  logic [4:0]  imm,
  input  logic        op_key_invupd,
  input  logic        op_permbits_inv,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rd
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d, rd_q, key_step, perm_step;
  logic [4:0]  cnt_q, cnt_d, dec;
  logic        key_q, key_d;
  function automatic logic [15:0] rotl16(input logic [15:0] h, input int s);
    logic [31:0] t;
    t = {h, h} << s;
    return t[31:16];
  endfunction
  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] t;
    t = {x, x} << s;
    return t[63:32];
  endfunction
  function automatic logic [31:0] kinv(input logic [31:0] x);
    return {rotl16(x[31:16], 2), rotl16(x[15:0], 12)};
  endfunction
  function automatic logic [31:0] swp(input logic [31:0] x, input int a, input logic [31:0] m);
    logic [31:0] t;
    t = (x ^ (x >> a)) & m;
    return x ^ t ^ (t << a);
  endfunction
`ifdef GIFT_ISE_INV_UNROLL4_EN
  logic [31:0] k1, k2, k3;
  assign k1 = kinv(acc_q);
  assign k2 = kinv(k1);
  assign k3 = kinv(k2);
  assign dec = !key_q ? 5'd1 : (cnt_q >= 5'd4 ? 5'd4 : cnt_q);
  assign key_step = dec == 5'd1 ? k1 : dec == 5'd2 ? k2 : dec == 5'd3 ? k3 : kinv(k3);
`else
  assign dec = 5'd1;
  assign key_step = kinv(acc_q);
`endif
  // cnt counts the remaining swap stages down from 4, widest swap first
  assign perm_step = cnt_q == 5'd4 ? swp(acc_q, 24, 32'h000000ff) :
                     cnt_q == 5'd3 ? swp(acc_q, 12, 32'h0000f0f0) :
                     cnt_q == 5'd2 ? swp(acc_q, 6, 32'h00cc00cc) :
                                     swp(acc_q, 3, 32'h0a0a0a0a);
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    key_d = key_q;
    case (state_q)
      IDLE: if (req_valid) begin
        key_d = op_key_invupd;
        acc_d = op_key_invupd ? rs1 : op_permbits_inv ? rotl32(rs1, imm) : 32'd0;
        cnt_d = op_key_invupd ? imm : op_permbits_inv ? 5'd4 : 5'd0;
        state_d = cnt_d == 5'd0 ? DONE : BUSY;
      end
      BUSY: begin
        acc_d = key_q ? key_step : perm_step;
        cnt_d = cnt_q - dec;
        state_d = cnt_d == 5'd0 ? DONE : BUSY;
      end
      DONE: state_d = rsp_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      key_q <= 1'b0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      key_q <= key_d;
      if (state_d == DONE && state_q != DONE) rd_q <= acc_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == DONE;
  assign rd = rd_q;
endmodule

// File: tb/tb_gift_ise_inv_seq.sv
// tb_gift_ise_inv_seq: directed and randomized checks against a closed-form reference model.
module tb_gift_ise_inv_seq;
  logic        clk = 0, rst = 1, req_valid = 0, op_key = 0, op_perm = 0, rsp_ready = 0;
  logic        req_ready, rsp_valid;
  logic [31:0] rs1 = 0, rd;
  logic [4:0]  imm = 0;
  int vectors = 0, miscompares = 0;

  gift_ise_inv_seq dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .rs1(rs1), .imm(imm),
    .op_key_invupd(op_key), .op_permbits_inv(op_perm), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rd(rd)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] r16(input logic [15:0] h, input int s);
    int m = s % 16;
    return m == 0 ? h : (h << m) | (h >> (16 - m));
  endfunction
  function automatic logic [31:0] r32(input logic [31:0] x, input int s);
    int m = s % 32;
    return m == 0 ? x : (x << m) | (x >> (32 - m));
  endfunction
  function automatic logic [31:0] ref_swp(input logic [31:0] x, input int a, input logic [31:0] m);
    logic [31:0] t = (x ^ (x >> a)) & m;
    return x ^ t ^ (t << a);
  endfunction
  function automatic logic [31:0] ref_key(input logic [31:0] x, input int n);
    return {r16(x[31:16], 2 * n), r16(x[15:0], 16 - ((4 * n) % 16))};
  endfunction
  function automatic logic [31:0] ref_pinv(input logic [31:0] x, input int i);
    int          sh[4] = '{24, 12, 6, 3};
    logic [31:0] mk[4] = '{32'h000000ff, 32'h0000f0f0, 32'h00cc00cc, 32'h0a0a0a0a};
    logic [31:0] y = r32(x, i);
    for (int k = 0; k < 4; k++) y = ref_swp(y, sh[k], mk[k]);
    return y;
  endfunction
  function automatic logic [31:0] fwd_perm(input logic [31:0] x, input int i);
    int          sh[4] = '{3, 6, 12, 24};
    logic [31:0] mk[4] = '{32'h0a0a0a0a, 32'h00cc00cc, 32'h0000f0f0, 32'h000000ff};
    logic [31:0] y = x;
    for (int k = 0; k < 4; k++) y = ref_swp(y, sh[k], mk[k]);
    return r32(y, 32 - i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic [31:0] a, input logic [4:0] i, input bit k, input bit p,
                     input int hold);
    logic [31:0] exp_rd;
    int exp_lat, lat;
    exp_rd = k ? ref_key(a, i) : p ? ref_pinv(a, i) : 32'd0;
`ifdef GIFT_ISE_INV_UNROLL4_EN
    exp_lat = k ? (i == 0 ? 1 : (i + 3) / 4 + 1) : p ? 5 : 1;
`else
    exp_lat = k ? (i == 0 ? 1 : i + 1) : p ? 5 : 1;
`endif
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    rs1 = a; imm = i; op_key = k; op_perm = p; req_valid = 1;
    step();
    req_valid = 0; rs1 = $urandom; imm = 5'($urandom); op_key = 1'($urandom); op_perm = 1'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      step();
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("rd", rd, exp_rd);
    req_valid = 1;
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_rd", rd, exp_rd);
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 0; rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("post_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_rd", rd, exp_rd);
  endtask

  initial begin
    logic [31:0] v;
    bit seen;
    #2;
    chk("rst_rd", rd, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    step();
    rst = 0;
    step();
    txn(32'h0000000F, 5'd1, 1, 0, 0);
    chk("t1_literal", rd, 32'h0000F000);
    txn(32'h00010000, 5'd1, 1, 0, 0);
    chk("t2a_literal", rd, 32'h00040000);
    txn(32'h12345678, 5'd4, 1, 0, 1);
    chk("t2b_literal", rd, 32'h34125678);
    v = fwd_perm(32'hDEADBEEF, 8);
    txn(v, 5'd8, 0, 1, 0);
    chk("t3_roundtrip", rd, 32'hDEADBEEF);
    txn(32'd0, 5'd19, 0, 1, 0);
    chk("t3_zero", rd, 32'd0);
    txn(32'h89ABCDEF, 5'd7, 1, 0, 3);
    txn(32'h13572468, 5'd2, 0, 1, 0);
    txn(32'hCAFEF00D, 5'd0, 1, 0, 0);
    chk("t5_imm0", rd, 32'hCAFEF00D);
    txn(32'h0F0F1234, 5'd3, 1, 1, 0);
    txn(32'hFFFFFFFF, 5'd9, 0, 0, 0);
    chk("t5_noop", rd, 32'd0);
    rs1 = 32'h55AA33CC; imm = 5'd31; op_key = 1; op_perm = 0; req_valid = 1;
    step();
    req_valid = 0;
    step(); step(); step();
    rst = 1;
    #1;
    chk("t6_rd", rd, 32'd0);
    chk("t6_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t6_ready", {31'd0, req_ready}, 32'd1);
    step();
    rst = 0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      seen |= rsp_valid;
    end
    chk("t6_no_rsp", {31'd0, seen}, 32'd0);
    txn(32'hA5A5F00F, 5'd5, 1, 0, 0);
    for (int r = 0; r < 40; r++) begin
      int sel = $urandom_range(0, 9);
      txn($urandom, 5'($urandom), sel < 5, sel >= 4, $urandom_range(0, 2));
    end
    for (int r = 0; r < 8; r++) begin
      int s = $urandom_range(0, 31);
      logic [31:0] x = $urandom;
      txn(fwd_perm(x, s), 5'(s), 0, 1, 0);
      chk("rand_roundtrip", rd, x);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
